// File: rtl/sctag_decc_err_log_ctl_if.sv
// sctag_decc_err_log_ctl_if: c7 syndrome/qualifier inputs and c8 classified error outputs
interface sctag_decc_err_log_ctl_if #(
   parameter int NWORDS = 4,
   parameter int CHKW = 6
);
   logic [NWORDS*CHKW-1:0] check_c7;
   logic [NWORDS-1:0]      parity_c7;
   logic                   scrub_half_c7;
   logic                   spc_rd_vld_c7;
   logic                   bsc_rd_vld_c7;
   logic                   scrub_rd_vld_c7;
   logic                   fb_rd_vld_c7;
   logic                   fb_corr_err_c7;
   logic                   fb_uncorr_err_c7;
   logic                   spcd_corr_c8;
   logic                   spcd_uncorr_c8;
   logic                   bscd_corr_c8;
   logic                   bscd_uncorr_c8;
   logic                   scrd_corr_c8;
   logic                   scrd_uncorr_c8;
   logic                   spcfb_corr_c8;
   logic                   spcfb_uncorr_c8;
   logic                   uncorr_err_c8;
   logic [2:0]             retdp_err_c8;
   modport master (
      output check_c7, parity_c7, scrub_half_c7, spc_rd_vld_c7, bsc_rd_vld_c7,
             scrub_rd_vld_c7, fb_rd_vld_c7, fb_corr_err_c7, fb_uncorr_err_c7,
      input  spcd_corr_c8, spcd_uncorr_c8, bscd_corr_c8, bscd_uncorr_c8, scrd_corr_c8,
             scrd_uncorr_c8, spcfb_corr_c8, spcfb_uncorr_c8, uncorr_err_c8, retdp_err_c8
   );
   modport slave (
      input  check_c7, parity_c7, scrub_half_c7, spc_rd_vld_c7, bsc_rd_vld_c7,
             scrub_rd_vld_c7, fb_rd_vld_c7, fb_corr_err_c7, fb_uncorr_err_c7,
      output spcd_corr_c8, spcd_uncorr_c8, bscd_corr_c8, bscd_uncorr_c8, scrd_corr_c8,
             scrd_uncorr_c8, spcfb_corr_c8, spcfb_uncorr_c8, uncorr_err_c8, retdp_err_c8
   );
endinterface

// File: rtl/sctag_decc_err_log_ctl.sv
// sctag_decc_err_log_ctl: L2 data-ECC error classifier, word select, first-error log and CE counter
// Optional CE counter/threshold flag built only when DECC_CE_THRESH_EN is defined.
module sctag_decc_err_log_ctl #(
   parameter int NWORDS = 4,
   parameter int CHKW = 6,
   parameter int BIST_DLY = 5,
   parameter int CNTW = 8,
   parameter int CE_THRESH = 16,
   localparam int SELW = $clog2(NWORDS)
) (
   input  logic                   rclk,
   input  logic                   rst,
   sctag_decc_err_log_ctl_if.slave dp,
   input  logic                   error_ceen,
   input  logic                   error_nceen,
   input  logic                   bist_enable_c1,
   input  logic [SELW-1:0]        bist_waddr_c1,
   input  logic                   diag_vld_c6,
   input  logic [SELW-1:0]        diag_waddr_c6,
   input  logic [SELW-1:0]        waddr_c6,
   input  logic                   log_clr,
   input  logic                   cnt_clr,
   output logic [SELW-1:0]        word_sel_c7,
   output logic                   log_vld,
   output logic                   log_uncorr,
   output logic [SELW-1:0]        log_word,
   output logic [CNTW-1:0]        ce_cnt,
   output logic                   ce_thresh_hit
);
   localparam logic [NWORDS-1:0] lo_msk = NWORDS'((1 << (NWORDS/2)) - 1);

   function automatic logic [SELW-1:0] low(input logic [NWORDS-1:0] v);
      low = '0;
      for (int i = NWORDS-1; i >= 0; i--) if (v[i]) low = SELW'(i);
   endfunction

   logic [NWORDS-1:0] ce, ue, half_msk;
   logic any_ce, any_ue, scr_ce, scr_ue;
   logic spcd_c, spcd_u, bscd_c, bscd_u, scrd_c, scrd_u, spcfb_c, spcfb_u;
   logic ev_ce, ev_ue, ev, cap;
   logic [2:0] ret_n;
   logic [SELW-1:0] word_n, sel_n;
   logic ceen_d1, nceen_d1;
   logic [SELW:0] bist_pipe [BIST_DLY];

   always_comb begin
      ce = dp.parity_c7;
      ue = '0;
      for (int i = 0; i < NWORDS; i++) ue[i] = |dp.check_c7[i*CHKW +: CHKW] & ~dp.parity_c7[i];
   end

   assign half_msk = dp.scrub_half_c7 ? lo_msk : ~lo_msk;
   assign any_ce = |ce;
   assign any_ue = |ue;
   assign scr_ce = |(ce & half_msk);
   assign scr_ue = |(ue & half_msk);
   assign spcd_c = any_ce & dp.spc_rd_vld_c7;
   assign spcd_u = any_ue & dp.spc_rd_vld_c7;
   assign bscd_c = any_ce & dp.bsc_rd_vld_c7;
   assign bscd_u = any_ue & dp.bsc_rd_vld_c7;
   assign scrd_c = scr_ce & dp.scrub_rd_vld_c7;
   assign scrd_u = scr_ue & dp.scrub_rd_vld_c7;
   assign spcfb_c = (any_ce & dp.fb_rd_vld_c7) | dp.fb_corr_err_c7;
   assign spcfb_u = (any_ue & dp.fb_rd_vld_c7) | dp.fb_uncorr_err_c7;
   assign ret_n = {1'b0,
      (any_ue | dp.fb_uncorr_err_c7) & (dp.spc_rd_vld_c7 | dp.fb_rd_vld_c7 | dp.fb_uncorr_err_c7) & nceen_d1,
      (any_ce | dp.fb_corr_err_c7) & (dp.spc_rd_vld_c7 | dp.fb_rd_vld_c7 | dp.fb_corr_err_c7) & ceen_d1};

   // Log is written on the same edge as the c8 outputs it describes
   assign ev_ce = spcd_c | bscd_c | scrd_c | spcfb_c;
   assign ev_ue = spcd_u | bscd_u | scrd_u | spcfb_u;
   assign ev = ev_ce | ev_ue;
   assign cap = ev & (~log_vld | log_clr | (~log_uncorr & ev_ue));
   assign word_n = (ev_ue & any_ue) ? low(ue) : (ev_ce & any_ce) ? low(ce) : '0;
   assign sel_n = bist_pipe[BIST_DLY-1][SELW] ? bist_pipe[BIST_DLY-1][SELW-1:0] :
                  diag_vld_c6 ? diag_waddr_c6 : waddr_c6;

   always_ff @(posedge rclk)
      if (rst) begin
         dp.spcd_corr_c8 <= 1'b0;
         dp.spcd_uncorr_c8 <= 1'b0;
         dp.bscd_corr_c8 <= 1'b0;
         dp.bscd_uncorr_c8 <= 1'b0;
         dp.scrd_corr_c8 <= 1'b0;
         dp.scrd_uncorr_c8 <= 1'b0;
         dp.spcfb_corr_c8 <= 1'b0;
         dp.spcfb_uncorr_c8 <= 1'b0;
         dp.uncorr_err_c8 <= 1'b0;
         dp.retdp_err_c8 <= '0;
         ceen_d1 <= 1'b0;
         nceen_d1 <= 1'b0;
         word_sel_c7 <= '0;
      end else begin
         dp.spcd_corr_c8 <= spcd_c;
         dp.spcd_uncorr_c8 <= spcd_u;
         dp.bscd_corr_c8 <= bscd_c;
         dp.bscd_uncorr_c8 <= bscd_u;
         dp.scrd_corr_c8 <= scrd_c;
         dp.scrd_uncorr_c8 <= scrd_u;
         dp.spcfb_corr_c8 <= spcfb_c;
         dp.spcfb_uncorr_c8 <= spcfb_u;
         dp.uncorr_err_c8 <= any_ue;
         dp.retdp_err_c8 <= ret_n;
         ceen_d1 <= error_ceen;
         nceen_d1 <= error_nceen;
         word_sel_c7 <= sel_n;
      end

   always_ff @(posedge rclk)
      if (rst) for (int k = 0; k < BIST_DLY; k++) bist_pipe[k] <= '0;
      else begin
         bist_pipe[0] <= {bist_enable_c1, bist_waddr_c1};
         for (int k = 1; k < BIST_DLY; k++) bist_pipe[k] <= bist_pipe[k-1];
      end

   always_ff @(posedge rclk)
      if (rst) begin
         log_vld <= 1'b0;
         log_uncorr <= 1'b0;
         log_word <= '0;
      end else if (cap) begin
         log_vld <= 1'b1;
         log_uncorr <= ev_ue;
         log_word <= word_n;
      end else if (log_clr) log_vld <= 1'b0;

`ifdef DECC_CE_THRESH_EN
   logic inc;
   logic [CNTW-1:0] cnt_n;
   assign inc = dp.spcd_corr_c8 | dp.bscd_corr_c8 | dp.scrd_corr_c8 | dp.spcfb_corr_c8;
   assign cnt_n = &ce_cnt ? ce_cnt : ce_cnt + CNTW'(1);
   always_ff @(posedge rclk)
      if (rst | cnt_clr) begin
         ce_cnt <= '0;
         ce_thresh_hit <= 1'b0;
      end else if (inc) begin
         ce_cnt <= cnt_n;
         ce_thresh_hit <= ce_thresh_hit | (32'(cnt_n) >= CE_THRESH);
      end
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr ^ (CE_THRESH == 0);
   assign ce_cnt = '0;
   assign ce_thresh_hit = 1'b0;
`endif
endmodule

// File: tb/tb_sctag_decc_err_log_ctl.sv
// tb_sctag_decc_err_log_ctl: directed scoreboard bench for the data-ECC error classifier/log
module tb_sctag_decc_err_log_ctl;
   localparam int NW = 4, CW = 6, BD = 5;
   localparam logic [26:0] M_C8 = 27'h7FF8000, M_WS = 27'h0006000, M_LOG = 27'h0001E00,
                           M_CNT = 27'h00001FF, M_ALL = 27'h7FFFFFF;
   typedef struct {int cyc; string nm; logic [26:0] m; logic [26:0] v;} exp_t;

   logic rclk = 1'b0, rst = 1'b1;
   logic error_ceen, error_nceen, bist_enable_c1, diag_vld_c6, log_clr, cnt_clr;
   logic [1:0] bist_waddr_c1, diag_waddr_c6, waddr_c6, word_sel_c7, log_word;
   logic log_vld, log_uncorr, ce_thresh_hit;
   logic [7:0] ce_cnt;
   logic [26:0] act;
   int ecnt = 0, total = 0, bad = 0;
   exp_t q[$];

   sctag_decc_err_log_ctl_if #(.NWORDS(NW), .CHKW(CW)) bus ();

   sctag_decc_err_log_ctl #(.NWORDS(NW), .CHKW(CW), .BIST_DLY(BD), .CNTW(8), .CE_THRESH(16)) dut (
      .rclk(rclk), .rst(rst), .dp(bus), .error_ceen(error_ceen), .error_nceen(error_nceen),
      .bist_enable_c1(bist_enable_c1), .bist_waddr_c1(bist_waddr_c1), .diag_vld_c6(diag_vld_c6),
      .diag_waddr_c6(diag_waddr_c6), .waddr_c6(waddr_c6), .log_clr(log_clr), .cnt_clr(cnt_clr),
      .word_sel_c7(word_sel_c7), .log_vld(log_vld), .log_uncorr(log_uncorr), .log_word(log_word),
      .ce_cnt(ce_cnt), .ce_thresh_hit(ce_thresh_hit));

   always #5 rclk = ~rclk;
   always @(posedge rclk) ecnt <= ecnt + 1;

   assign act = {bus.spcd_corr_c8, bus.spcd_uncorr_c8, bus.bscd_corr_c8, bus.bscd_uncorr_c8,
                 bus.scrd_corr_c8, bus.scrd_uncorr_c8, bus.spcfb_corr_c8, bus.spcfb_uncorr_c8,
                 bus.uncorr_err_c8, bus.retdp_err_c8, word_sel_c7, log_vld, log_uncorr, log_word,
                 ce_thresh_hit, ce_cnt};

   function automatic logic [26:0] f(logic [7:0] c8, logic unc, logic [2:0] ret, logic [1:0] ws,
                                     logic lv, logic lu, logic [1:0] lw, logic hit, logic [7:0] cnt);
      return {c8, unc, ret, ws, lv, lu, lw, hit, cnt};
   endfunction

   task automatic push(input int k, input string nm, input logic [26:0] m, input logic [26:0] v);
      q.push_back('{ecnt + k, nm, m, v});
   endtask

   task automatic step();
      @(negedge rclk);
      bus.check_c7 = '0;
      bus.parity_c7 = '0;
      bus.scrub_half_c7 = 1'b0;
      bus.spc_rd_vld_c7 = 1'b0;
      bus.bsc_rd_vld_c7 = 1'b0;
      bus.scrub_rd_vld_c7 = 1'b0;
      bus.fb_rd_vld_c7 = 1'b0;
      bus.fb_corr_err_c7 = 1'b0;
      bus.fb_uncorr_err_c7 = 1'b0;
      bist_enable_c1 = 1'b0;
      bist_waddr_c1 = '0;
      diag_vld_c6 = 1'b0;
      diag_waddr_c6 = '0;
      waddr_c6 = '0;
      log_clr = 1'b0;
      cnt_clr = 1'b0;
   endtask

   // Monitor: compares every queued expectation on the cycle it is due
   initial forever begin
      @(posedge rclk);
      #1;
      while (q.size() != 0 && q[0].cyc <= ecnt) begin
         total++;
         if (q[0].cyc < ecnt) begin
            bad++;
            $display("FAIL %s not checked in time (due %0d now %0d)", q[0].nm, q[0].cyc, ecnt);
         end else if ((act & q[0].m) !== (q[0].v & q[0].m)) begin
            bad++;
            $display("FAIL %s cyc=%0d act=%h exp=%h mask=%h", q[0].nm, ecnt, act & q[0].m,
                     q[0].v & q[0].m, q[0].m);
         end
         void'(q.pop_front());
      end
   end

   initial begin
      error_ceen = 1'b0;
      error_nceen = 1'b0;
      step();
      push(1, "rst_state", M_ALL, '0);
      step();
      step();
      rst = 1'b0;
      error_ceen = 1'b1;
      error_nceen = 1'b1;
      push(1, "post_rst_idle", M_ALL, '0);
      // CE on word 2 from a core read
      step(); bus.parity_c7 = 4'b0100; bus.spc_rd_vld_c7 = 1'b1;
      push(1, "t1_ce_w2", M_C8 | M_WS | M_LOG, f(8'h80, 0, 3'b001, 0, 1, 0, 2, 0, 0));
      step();
      push(1, "t1_hold", M_C8 | M_LOG, f(0, 0, 0, 0, 1, 0, 2, 0, 0));
      step(); log_clr = 1'b1;
      push(1, "t1_clr", M_C8 | M_LOG, f(0, 0, 0, 0, 0, 0, 2, 0, 0));
      // scrub UE on word 1, lower then upper half
      step(); bus.check_c7 = 24'h000140; bus.scrub_rd_vld_c7 = 1'b1; bus.scrub_half_c7 = 1'b1;
      push(1, "t2_scr_lo", M_C8 | M_LOG, f(8'h04, 1, 0, 0, 1, 1, 1, 0, 0));
      step(); bus.check_c7 = 24'h000140; bus.scrub_rd_vld_c7 = 1'b1;
      push(1, "t2_scr_hi", M_C8 | M_LOG, f(0, 1, 0, 0, 1, 1, 1, 0, 0));
      step(); log_clr = 1'b1;
      push(1, "t2_clr", M_C8 | M_LOG, f(0, 0, 0, 0, 0, 1, 1, 0, 0));
      // log upgrade, hold and clear-with-event
      step(); bus.parity_c7 = 4'b1000; bus.bsc_rd_vld_c7 = 1'b1;
      push(1, "t3_ce_w3", M_C8 | M_LOG, f(8'h20, 0, 0, 0, 1, 0, 3, 0, 0));
      step(); bus.check_c7 = 24'h000001; bus.bsc_rd_vld_c7 = 1'b1;
      push(1, "t3_ue_upg", M_C8 | M_LOG, f(8'h10, 1, 0, 0, 1, 1, 0, 0, 0));
      step(); bus.parity_c7 = 4'b1000; bus.bsc_rd_vld_c7 = 1'b1;
      push(1, "t3_ue_hold", M_C8 | M_LOG, f(8'h20, 0, 0, 0, 1, 1, 0, 0, 0));
      step(); bus.parity_c7 = 4'b0100; bus.bsc_rd_vld_c7 = 1'b1; log_clr = 1'b1;
      push(1, "t3_clr_ev", M_C8 | M_LOG, f(8'h20, 0, 0, 0, 1, 0, 2, 0, 0));
      step(); log_clr = 1'b1;
      push(1, "t3_clr", M_C8 | M_LOG, f(0, 0, 0, 0, 0, 0, 2, 0, 0));
      step(); bus.fb_uncorr_err_c7 = 1'b1;
      push(1, "fb_ue_only", M_C8 | M_LOG, f(8'h01, 0, 3'b010, 0, 1, 1, 0, 0, 0));
      step(); bus.check_c7 = 24'h03F000; bus.spc_rd_vld_c7 = 1'b1;
      push(1, "spc_ue_w2", M_C8 | M_LOG, f(8'h40, 1, 3'b010, 0, 1, 1, 0, 0, 0));
      step(); bus.parity_c7 = 4'b0010; bus.fb_rd_vld_c7 = 1'b1; bus.fb_corr_err_c7 = 1'b1;
      push(1, "fb_ce", M_C8 | M_LOG, f(8'h02, 0, 3'b001, 0, 1, 1, 0, 0, 0));
      step(); error_ceen = 1'b0;
      push(1, "ceen_off_idle", M_C8, '0);
      step(); bus.parity_c7 = 4'b0001; bus.spc_rd_vld_c7 = 1'b1;
      push(1, "ceen_off_ce", M_C8, f(8'h80, 0, 0, 0, 0, 0, 0, 0, 0));
      step(); error_ceen = 1'b1;
      push(1, "ceen_on_idle", M_C8, '0);
      step(); bus.check_c7 = 24'h00003F; bus.parity_c7 = 4'b0001; bus.spc_rd_vld_c7 = 1'b1;
      push(1, "par_wins", M_C8 | M_LOG, f(8'h80, 0, 3'b001, 0, 1, 1, 0, 0, 0));
      // bist address overrides diag after BD stages
      step(); diag_vld_c6 = 1'b1; diag_waddr_c6 = 2'd1; waddr_c6 = 2'd2;
      bist_enable_c1 = 1'b1; bist_waddr_c1 = 2'd3;
      push(BD, "t4_diag", M_WS, f(0, 0, 0, 1, 0, 0, 0, 0, 0));
      push(BD + 1, "t4_bist", M_WS, f(0, 0, 0, 3, 0, 0, 0, 0, 0));
      push(BD + 2, "t4_diag2", M_WS, f(0, 0, 0, 1, 0, 0, 0, 0, 0));
      repeat (BD + 1) begin
         step(); diag_vld_c6 = 1'b1; diag_waddr_c6 = 2'd1; waddr_c6 = 2'd2;
      end
      step(); waddr_c6 = 2'd2;
      push(1, "t4_norm", M_WS, f(0, 0, 0, 2, 0, 0, 0, 0, 0));
`ifdef DECC_CE_THRESH_EN
      step(); cnt_clr = 1'b1;
      push(1, "t5_clr", M_CNT, '0);
      for (int n = 1; n <= 300; n++) begin
         step(); bus.parity_c7 = 4'b0001; bus.spc_rd_vld_c7 = 1'b1;
         push(2, "t5_cnt", M_CNT, f(0, 0, 0, 0, 0, 0, 0, n >= 16, (n > 255) ? 8'd255 : 8'(n)));
      end
      step(); bus.parity_c7 = 4'b0001; bus.spc_rd_vld_c7 = 1'b1; cnt_clr = 1'b1;
      push(1, "t5_clr_ce", M_CNT, '0);
      step();
      push(1, "t5_after_clr", M_CNT, f(0, 0, 0, 0, 0, 0, 0, 0, 8'd1));
`else
      step(); bus.parity_c7 = 4'b0001; bus.spc_rd_vld_c7 = 1'b1;
      push(2, "t5_nocnt", M_CNT, '0);
      step(); bus.parity_c7 = 4'b0001; bus.spc_rd_vld_c7 = 1'b1;
      push(2, "t5_nocnt2", M_CNT, '0);
`endif
      step(); rst = 1'b1; bus.check_c7 = 24'h000001; bus.spc_rd_vld_c7 = 1'b1;
      push(1, "t6_rst", M_ALL, '0);
      step(); rst = 1'b0;
      push(1, "t6_post", M_ALL, '0);
      repeat (3) step();
      while (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL %s never checked (due %0d)", q[0].nm, q[0].cyc);
         void'(q.pop_front());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
